// File: rtl/wb_arbiter.sv
// wb_arbiter
//   Round-robin arbiter that lets N_MASTERS Wishbone masters share one slave.
//   Ownership is locked for as long as the owner keeps CYC high, so block and
//   read-modify-write cycles are never split. A watchdog aborts a stalled
//   access with a one-cycle ERR to the owner when the slave never terminates.
//
// Ports
//   clk, rst_n        : clock (rising edge) and asynchronous active-low reset
//   m_cyc/m_stb/m_we  : per-master request strobes, bit i = master i
//   m_adr/m_dat_ms/m_sel : packed per-master fields, master i at [i*W +: W]
//   m_ack/m_err/m_rty : per-master terminations, only the owner's bit can be set
//   m_dat_sm          : slave read data broadcast to every master
//   s_cyc..s_sel      : request forwarded to the shared slave
//   s_dat_sm, s_ack, s_err, s_rty : slave response
//   grant             : registered one-hot owner, all-zero while idle
module wb_arbiter #(
  parameter int N_MASTERS      = 3,
  parameter int ADR_BITS       = 16,
  parameter int DAT_BITS       = 32,
  parameter int SEL_BITS       = 4,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N_MASTERS-1:0]          m_cyc,
  input  logic [N_MASTERS-1:0]          m_stb,
  input  logic [N_MASTERS-1:0]          m_we,
  input  logic [N_MASTERS*ADR_BITS-1:0] m_adr,
  input  logic [N_MASTERS*DAT_BITS-1:0] m_dat_ms,
  input  logic [N_MASTERS*SEL_BITS-1:0] m_sel,
  output logic [N_MASTERS-1:0]          m_ack,
  output logic [N_MASTERS-1:0]          m_err,
  output logic [N_MASTERS-1:0]          m_rty,
  output logic [DAT_BITS-1:0]           m_dat_sm,
  output logic                          s_cyc,
  output logic                          s_stb,
  output logic                          s_we,
  output logic [ADR_BITS-1:0]           s_adr,
  output logic [DAT_BITS-1:0]           s_dat_ms,
  output logic [SEL_BITS-1:0]           s_sel,
  input  logic [DAT_BITS-1:0]           s_dat_sm,
  input  logic                          s_ack,
  input  logic                          s_err,
  input  logic                          s_rty,
  output logic [N_MASTERS-1:0]          grant
);

  localparam int IDX_W = $clog2(N_MASTERS);
  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Saturation point of the watchdog; stays at zero when the watchdog is off.
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST    = IDX_W'(N_MASTERS - 1);
  localparam logic [N_MASTERS-1:0] ONE = {{(N_MASTERS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, OWNED, ABORT} state_t;

  state_t           state;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] rr_ptr;
  logic [CNT_W-1:0] wdog;

  logic [IDX_W-1:0] pick;
  logic             pick_vld;
  logic [IDX_W-1:0] owner_next;
  logic             owned;
  logic             term;
  logic             stall;
  logic             wdog_fire;
  int               idx;

  // Round-robin search: first master with CYC high, starting at rr_ptr.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = 0;
    for (int i = 0; i < N_MASTERS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      if (!pick_vld && m_cyc[idx]) begin
        pick     = IDX_W'(idx);
        pick_vld = 1'b1;
      end
    end
  end

  assign owner_next = (owner == LAST) ? '0 : owner + 1'b1;
  assign owned      = (state == OWNED);
  assign term       = s_ack | s_err | s_rty;
  assign stall      = owned && s_stb && !term;
  // A termination in the limit cycle wins because stall is already low then.
  assign wdog_fire  = (TIMEOUT_CYCLES > 0) && (wdog == CNT_MAX) && stall;

  // Request mux: the owner's fields reach the slave only while OWNED, so the
  // ABORT cycle drops CYC/STB and the slave sees the access end.
  always_comb begin
    s_cyc    = 1'b0;
    s_stb    = 1'b0;
    s_we     = 1'b0;
    s_adr    = '0;
    s_dat_ms = '0;
    s_sel    = '0;
    if (owned) begin
      s_cyc    = m_cyc[owner];
      s_stb    = m_stb[owner];
      s_we     = m_we[owner];
      s_adr    = m_adr[owner*ADR_BITS +: ADR_BITS];
      s_dat_ms = m_dat_ms[owner*DAT_BITS +: DAT_BITS];
      s_sel    = m_sel[owner*SEL_BITS +: SEL_BITS];
    end
  end

  // grant is one-hot on the owner, so it doubles as the response steering mask.
  assign m_ack    = (owned && s_ack) ? grant : '0;
  assign m_err    = ((owned && s_err) || (state == ABORT)) ? grant : '0;
  assign m_rty    = (owned && s_rty) ? grant : '0;
  assign m_dat_sm = s_dat_sm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      grant  <= '0;
      owner  <= '0;
      rr_ptr <= '0;
      wdog   <= '0;
    end else begin
      case (state)
        IDLE: begin
          wdog <= '0;
          if (pick_vld) begin
            owner <= pick;
            grant <= ONE << pick;
            state <= OWNED;
          end
        end
        OWNED: begin
          if (!m_cyc[owner]) begin
            grant  <= '0;
            rr_ptr <= owner_next;
            wdog   <= '0;
            state  <= IDLE;
          end else if (wdog_fire) begin
            state <= ABORT;
          end else if (stall) begin
            if (wdog != CNT_MAX) wdog <= wdog + 1'b1;
          end else begin
            wdog <= '0;
          end
        end
        ABORT: begin
          wdog <= '0;
          if (m_cyc[owner]) begin
            state <= OWNED;
          end else begin
            grant  <= '0;
            rr_ptr <= owner_next;
            state  <= IDLE;
          end
        end
        default: begin
          grant <= '0;
          wdog  <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter
//   Bench for wb_arbiter with default parameters (3 masters, 16-bit address,
//   32-bit data, 4-bit select, watchdog 16). A reference model of the bus
//   (who owns it, whose turn is next, how long the slave has stalled) predicts
//   every output each cycle; directed sequences pin literal expectations.
module tb_wb_arbiter;

  localparam int NM = 3;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [2:0]  m_cyc, m_stb, m_we;
  logic [47:0] m_adr;
  logic [95:0] m_dat_ms;
  logic [11:0] m_sel;
  logic [2:0]  m_ack, m_err, m_rty;
  logic [31:0] m_dat_sm;
  logic        s_cyc, s_stb, s_we;
  logic [15:0] s_adr;
  logic [31:0] s_dat_ms;
  logic [3:0]  s_sel;
  logic [31:0] s_dat_sm;
  logic        s_ack, s_err, s_rty;
  logic [2:0]  grant;

  int total = 0;
  int bad   = 0;

  // Reference model: owner (-1 = bus free), next-turn pointer, count of
  // consecutive stalled cycles, and whether the current cycle is an abort.
  int md_owner = -1;
  int md_ptr   = 0;
  int md_stall = 0;
  bit md_abort = 1'b0;

  wb_arbiter #(
    .N_MASTERS(NM), .ADR_BITS(16), .DAT_BITS(32), .SEL_BITS(4), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .m_cyc(m_cyc), .m_stb(m_stb), .m_we(m_we),
    .m_adr(m_adr), .m_dat_ms(m_dat_ms), .m_sel(m_sel),
    .m_ack(m_ack), .m_err(m_err), .m_rty(m_rty), .m_dat_sm(m_dat_sm),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we),
    .s_adr(s_adr), .s_dat_ms(s_dat_ms), .s_sel(s_sel),
    .s_dat_sm(s_dat_sm), .s_ack(s_ack), .s_err(s_err), .s_rty(s_rty),
    .grant(grant)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Per-cycle comparison against the model, then advance the model with the
  // inputs the DUT will sample on the coming rising edge.
  always @(negedge clk) begin
    logic [2:0] e_bit;
    logic       own;
    int         oi;
    bit         found;
    int         c;
    if (!rst_n) begin
      md_owner = -1;
      md_ptr   = 0;
      md_stall = 0;
      md_abort = 1'b0;
    end
    own   = (md_owner >= 0) && !md_abort;
    oi    = (md_owner >= 0) ? md_owner : 0;
    e_bit = (md_owner >= 0) ? (3'b001 << md_owner) : 3'b000;
    chk("grant",    grant,    e_bit);
    chk("s_cyc",    s_cyc,    own ? m_cyc[oi] : 1'b0);
    chk("s_stb",    s_stb,    own ? m_stb[oi] : 1'b0);
    chk("s_we",     s_we,     own ? m_we[oi]  : 1'b0);
    chk("s_adr",    s_adr,    own ? m_adr[oi*16 +: 16]    : 16'h0);
    chk("s_dat_ms", s_dat_ms, own ? m_dat_ms[oi*32 +: 32] : 32'h0);
    chk("s_sel",    s_sel,    own ? m_sel[oi*4 +: 4]      : 4'h0);
    chk("m_ack",    m_ack,    (own && s_ack) ? e_bit : 3'b000);
    chk("m_err",    m_err,    ((own && s_err) || md_abort) ? e_bit : 3'b000);
    chk("m_rty",    m_rty,    (own && s_rty) ? e_bit : 3'b000);
    chk("m_dat_sm", m_dat_sm, s_dat_sm);

    if (rst_n) begin
      if (md_owner < 0) begin
        found = 1'b0;
        for (int i = 0; i < NM; i++) begin
          c = (md_ptr + i) % NM;
          if (!found && m_cyc[c]) begin
            found    = 1'b1;
            md_owner = c;
          end
        end
        md_stall = 0;
      end else if (md_abort) begin
        md_abort = 1'b0;
        md_stall = 0;
        if (!m_cyc[md_owner]) begin
          md_ptr   = (md_owner + 1) % NM;
          md_owner = -1;
        end
      end else if (!m_cyc[md_owner]) begin
        md_ptr   = (md_owner + 1) % NM;
        md_owner = -1;
        md_stall = 0;
      end else if (m_stb[md_owner] && !(s_ack || s_err || s_rty)) begin
        md_stall = md_stall + 1;
        if (md_stall == TO) md_abort = 1'b1;
      end else begin
        md_stall = 0;
      end
    end
  end

  initial begin
    bit silent;
    rst_n = 1'b0;
    m_cyc = '0; m_stb = '0; m_we = '0;
    m_adr = '0; m_dat_ms = '0; m_sel = '0;
    s_dat_sm = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    silent = 1'b0;

    // Reset state and round-robin order with all three masters requesting.
    step(); step();
    #1 chk("rst_grant", grant, 3'b000);
    chk("rst_s_cyc", s_cyc, 1'b0);
    step();
    rst_n = 1'b1;
    m_cyc = 3'b111;
    #1 chk("arb_latency", grant, 3'b000);
    step();
    #1 chk("rr_grant0", grant, 3'b001);
    m_cyc = 3'b110;
    step();
    #1 chk("rr_idle0", grant, 3'b000);
    step();
    #1 chk("rr_grant1", grant, 3'b010);
    m_cyc = 3'b100;
    step(); step();
    #1 chk("rr_grant2", grant, 3'b100);
    m_cyc = 3'b000;
    step(); step();

    // Master 1 single write, slave acks two cycles after the grant.
    m_cyc = 3'b010; m_stb = 3'b010; m_we = 3'b010;
    m_adr    = {16'h0000, 16'h1234, 16'h0000};
    m_dat_ms = {32'h0, 32'hDEADBEEF, 32'h0};
    m_sel    = 12'h0F0;
    step();
    #1 chk("wr_grant", grant, 3'b010);
    chk("wr_s_adr", s_adr, 16'h1234);
    chk("wr_s_dat", s_dat_ms, 32'hDEADBEEF);
    chk("wr_s_sel", s_sel, 4'hF);
    chk("wr_s_we", s_we, 1'b1);
    step(); step();
    s_ack = 1'b1;
    #1 chk("wr_m_ack", m_ack, 3'b010);
    step();
    s_ack = 1'b0; m_cyc = '0; m_stb = '0; m_we = '0;
    #1 chk("wr_ack_gone", m_ack, 3'b000);
    step();

    // Locked burst: master 2 waits while master 0 holds CYC.
    m_cyc = 3'b001; m_stb = 3'b001;
    step();
    #1 chk("lock_grant", grant, 3'b001);
    m_cyc = 3'b101; s_ack = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1 chk("lock_hold", grant, 3'b001);
      chk("lock_ack", m_ack, 3'b001);
      step();
    end
    s_ack = 1'b0; m_cyc = 3'b100; m_stb = 3'b000;
    #1 chk("lock_last", grant, 3'b001);
    step();
    #1 chk("lock_idle", grant, 3'b000);
    step();
    #1 chk("lock_next", grant, 3'b100);
    m_cyc = '0;
    step(); step();

    // Watchdog: slave never answers, abort in the 17th strobe cycle.
    m_cyc = 3'b001; m_stb = 3'b001;
    step();
    for (int k = 1; k <= TO; k++) begin
      #1 chk("wd_no_err", m_err, 3'b000);
      chk("wd_s_cyc", s_cyc, 1'b1);
      step();
    end
    #1 chk("wd_abort_err", m_err, 3'b001);
    chk("wd_abort_cyc", s_cyc, 1'b0);
    chk("wd_abort_stb", s_stb, 1'b0);
    chk("wd_abort_grant", grant, 3'b001);
    step();
    #1 chk("wd_after_err", m_err, 3'b000);
    chk("wd_after_cyc", s_cyc, 1'b1);
    m_cyc = '0; m_stb = '0;
    step(); step();

    // Ack in the 16th stalled cycle beats the watchdog and restarts it.
    m_cyc = 3'b010; m_stb = 3'b010;
    step();
    for (int k = 1; k < TO; k++) begin
      #1 chk("late_no_err", m_err, 3'b000);
      step();
    end
    s_ack = 1'b1;
    #1 chk("late_ack", m_ack, 3'b010);
    chk("late_ack_err", m_err, 3'b000);
    step();
    s_ack = 1'b0;
    for (int k = 1; k < TO; k++) begin
      #1 chk("late_restart", m_err, 3'b000);
      chk("late_s_cyc", s_cyc, 1'b1);
      step();
    end
    m_cyc = '0; m_stb = '0;
    step(); step();

    // Reset during a master 2 read.
    m_cyc = 3'b100; m_stb = 3'b100; m_we = 3'b000;
    step();
    #1 chk("rrd_grant", grant, 3'b100);
    step();
    rst_n = 1'b0;
    #1 chk("arst_grant", grant, 3'b000);
    chk("arst_s_cyc", s_cyc, 1'b0);
    s_ack = 1'b1;
    #1 chk("arst_ack", m_ack, 3'b000);
    chk("arst_err", m_err, 3'b000);
    s_ack = 1'b0;
    step();
    rst_n = 1'b1; m_cyc = 3'b101; m_stb = 3'b000;
    step();
    #1 chk("arst_regrant", grant, 3'b001);
    m_cyc = '0;
    step(); step();

    // Randomized traffic with quiet-slave phases long enough to hit the watchdog.
    for (int c = 0; c < 3000; c++) begin
      step();
      if (c % 80 == 0) silent = ($urandom_range(0, 1) == 1);
      for (int i = 0; i < NM; i++) begin
        if (m_cyc[i]) begin
          if ($urandom_range(0, silent ? 40 : 7) == 0) m_cyc[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          m_cyc[i] = 1'b1;
        end
        m_stb[i] = m_cyc[i] & (silent || ($urandom_range(0, 3) != 0));
        m_we[i]  = ($urandom_range(0, 1) == 1);
      end
      m_adr    = 48'({$urandom(), $urandom()});
      m_dat_ms = {$urandom(), $urandom(), $urandom()};
      m_sel    = 12'($urandom());
      s_dat_sm = $urandom();
      if (silent) begin
        s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
      end else begin
        s_ack = ($urandom_range(0, 2) == 0);
        s_err = ($urandom_range(0, 15) == 0);
        s_rty = ($urandom_range(0, 15) == 0);
      end
      rst_n = ($urandom_range(0, 699) != 0);
    end

    step();
    rst_n = 1'b1;
    m_cyc = '0; m_stb = '0; s_ack = 1'b0; s_err = 1'b0; s_rty = 1'b0;
    step(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter N_MASTERS, default 3: number of requesting Wishbone masters (2..8).
REQ-002 SHALL have parameter ADR_BITS, default 16: address width, shared by all ports.
REQ-003 SHALL have parameter DAT_BITS, default 32: data width, shared by all ports (8/16/32/64).
REQ-004 SHALL have parameter SEL_BITS, default 4: select width, shared by all ports.
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 16: bus-error watchdog limit; 0 disables the watchdog.
REQ-006 SHALL have port clk  in  1: single clock; all state updates on rising edge.
REQ-007 SHALL have port rst_n  in  1: asynchronous, active-low reset.
REQ-008 SHALL have ports m_cyc, m_stb, m_we  in  N_MASTERS each: per-master CYC/STB/WE.
REQ-009 SHALL have ports m_adr  in  N_MASTERS*ADR_BITS, m_dat_ms  in  N_MASTERS*DAT_BITS, m_sel  in  N_MASTERS*SEL_BITS: packed per-master fields, master i at slice [i*W +: W].
REQ-010 SHALL have ports m_ack, m_err, m_rty  out  N_MASTERS each: per-master terminations.
REQ-011 SHALL have port m_dat_sm  out  DAT_BITS: read data broadcast to all masters.
REQ-012 SHALL have ports s_cyc, s_stb, s_we  out  1, s_adr  out  ADR_BITS, s_dat_ms  out  DAT_BITS, s_sel  out  SEL_BITS: shared slave request.
REQ-013 SHALL have ports s_dat_sm  in  DAT_BITS, s_ack, s_err, s_rty  in  1: slave response.
REQ-014 SHALL have port grant  out  N_MASTERS: registered one-hot owner vector; all-zero when idle.

Function
REQ-015 SHALL implement states IDLE, OWNED, ABORT.
REQ-016 In IDLE with any m_cyc high, SHALL select the first requester at or after rr_ptr (wrapping modulo N_MASTERS), set grant one-hot and enter OWNED on the next edge (one-cycle arbitration latency).
REQ-017 In IDLE with no m_cyc high, SHALL stay in IDLE with grant all-zero.
REQ-018 In OWNED, SHALL hold grant while the owner's m_cyc stays high (locked cycle; other requests ignored, including block/RMW cycles).
REQ-019 In OWNED, when owner's m_cyc is low, SHALL clear grant, set rr_ptr = owner+1 (wrapping N_MASTERS-1 -> 0) and enter IDLE on the next edge.
REQ-020 When grant is non-zero and state is OWNED, SHALL drive s_cyc/s_stb/s_we/s_adr/s_dat_ms/s_sel combinationally from the owner's inputs.
REQ-021 When grant is zero or state is ABORT, SHALL drive s_cyc, s_stb, s_we, s_adr, s_dat_ms, s_sel all zero.
REQ-022 SHALL route s_ack/s_err/s_rty combinationally to the owner's m_ack/m_err/m_rty only in OWNED; all other bits zero.
REQ-023 SHALL drive m_dat_sm = s_dat_sm at all times.
REQ-024 Watchdog counter SHALL increment each OWNED cycle with s_stb high and s_ack, s_err, s_rty all low, and SHALL clear otherwise.
REQ-025 When TIMEOUT_CYCLES>0 and counter equals TIMEOUT_CYCLES-1 with no termination that cycle, SHALL enter ABORT on the next edge.
REQ-026 In ABORT (exactly one cycle), SHALL assert owner's m_err, force s_cyc=s_stb=0, clear counter, then return to OWNED if owner's m_cyc is high, else to IDLE with rr_ptr advanced as in REQ-019.
REQ-027 Counter SHALL saturate at TIMEOUT_CYCLES-1 and be width $clog2(TIMEOUT_CYCLES+1), minimum 1 bit.
REQ-028 A termination arriving on the same cycle the counter reaches its limit SHALL take priority; no ABORT.

Reset
REQ-029 On rst_n low, SHALL immediately set state IDLE, grant 0, rr_ptr 0, counter 0; consequently all s_* request outputs and all m_ack/m_err/m_rty are 0.
REQ-030 Reset asserted mid-transaction SHALL abandon the transaction with no termination to any master; first grant after release follows REQ-016 with rr_ptr 0.

Verification
REQ-031 Reset release, m_cyc=3'b111 held -> grant 3'b001 after one edge, then 3'b010, then 3'b100, each after its owner drops cyc plus one IDLE cycle.
REQ-032 Master 1 alone, write adr=0x1234, dat=0xDEADBEEF, sel=4'hF, slave acks 2 cycles later -> s_adr=0x1234, s_dat_ms=0xDEADBEEF, m_ack=3'b010 for one cycle, m_ack[0]=m_ack[2]=0.
REQ-033 Master 0 owns, master 2 raises cyc, master 0 issues 3 acked beats with cyc held -> grant stays 3'b001 throughout; grant 3'b100 only after master 0 drops cyc.
REQ-034 TIMEOUT_CYCLES=16, owner stb high, slave never responds -> ABORT entered on 17th cycle of stb, m_err[owner]=1 and s_cyc=0 for exactly one cycle.
REQ-035 Ack arriving in the 16th stalled cycle -> normal m_ack, no m_err, counter cleared.
REQ-036 rst_n pulsed low during master 2 read -> grant 0 and s_cyc 0 asynchronously, no m_ack/m_err; after release with m_cyc=3'b101, grant=3'b001.
